hull_fifo_reader: RTL and testbench

Read-side drain adapter for the HullFIFO abstraction. Consumes a FIFO read port (q/empty/rdreq) with either 0-cycle (show-ahead/fwft) or 1-cycle read latency. Presents the data as a registered valid/ready stream to downstream logic. Sustains one word per cycle with no combinational path from `out_ready` to `fifo_rdreq`, so it can sit between any FIFO TYPE and timing-critical consumers.

---
 rtl/hull_fifo_pkg.sv | 14 +
 rtl/hull_fifo_reader_buf.sv | 53 +++++
 rtl/hull_fifo_reader.sv | 81 ++++++++
 tb/tb_hull_fifo_reader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hull_fifo_pkg.sv
// Shared types and sizing helpers for the HullFIFO read-side drain adapter.
package hull_fifo_pkg;

    localparam int unsigned MAX_READ_LATENCY = 1;
    localparam int unsigned BEAT_COUNT_W     = 32;

    typedef logic [BEAT_COUNT_W-1:0] beat_count_t;

    // Entries needed to keep one beat per cycle while absorbing in-flight reads.
    function automatic int unsigned reader_depth(input int unsigned lat);
        return lat + 2;
    endfunction

endpackage

// File: rtl/hull_fifo_reader_buf.sv
// Small circular register buffer with head/tail pointers and an occupancy count.
module hull_fifo_reader_buf #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   occ
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage, pointers and occupancy; push/pop together leave occ unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign head_data = mem[head];

endmodule

// File: rtl/hull_fifo_reader.sv
// Drains a 0- or 1-cycle-latency FIFO read port into a valid/ready stream.
// Optional beat counter port enabled by defining HULL_FIFO_READER_STATS_EN.
module hull_fifo_reader
    import hull_fifo_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned READ_LATENCY = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_q,
    output logic             fifo_rdreq,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef HULL_FIFO_READER_STATS_EN
    ,
    output beat_count_t      beat_count
`endif
);

    localparam int unsigned DEPTH = reader_depth(READ_LATENCY);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = OCC_W + 1;

    if (READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("hull_fifo_reader: READ_LATENCY must be 0 or 1");
    end

    logic [OCC_W-1:0] occ;
    logic [SUM_W-1:0] pending;
    logic             inflight;
    logic             push;
    logic             pop;

    // Request depends only on registered occupancy, never on out_ready.
    assign pending    = SUM_W'(occ) + SUM_W'(inflight);
    assign fifo_rdreq = !reset && !fifo_empty && (pending < SUM_W'(DEPTH));
    assign out_valid  = (occ != '0);
    assign pop        = out_valid && out_ready;

    if (READ_LATENCY == 0) begin : g_lat0
        assign inflight = 1'b0;
        assign push     = fifo_rdreq;
    end else begin : g_lat1
        // Data for a request returns on the following edge whatever fifo_empty says.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                inflight <= 1'b0;
            end else begin
                inflight <= fifo_rdreq;
            end
        end
        assign push = inflight;
    end

    hull_fifo_reader_buf #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_buf (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (fifo_q),
        .pop       (pop),
        .head_data (out_data),
        .occ       (occ)
    );

`ifdef HULL_FIFO_READER_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beat_count <= '0;
        end else if (pop) begin
            beat_count <= beat_count + beat_count_t'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hull_fifo_reader.sv
// Randomised self-checking bench: lane 0 runs READ_LATENCY 0, lane 1 runs READ_LATENCY 1.
`timescale 1ns/1ps
module tb_hull_fifo_reader;
    import hull_fifo_pkg::*;

    localparam int unsigned W     = 32;
    localparam int          UP_SZ = 16384;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         fifo_empty0 = 1'b1, fifo_empty1 = 1'b1;
    logic [W-1:0] fifo_q0 = '0, fifo_q1 = '0;
    logic         out_ready0 = 1'b0, out_ready1 = 1'b0;
    logic         fifo_rdreq0, fifo_rdreq1;
    logic         out_valid0, out_valid1;
    logic [W-1:0] out_data0, out_data1;
`ifdef HULL_FIFO_READER_STATS_EN
    beat_count_t  beat_count0, beat_count1;
`endif

    always #5 clock = ~clock;

    hull_fifo_reader #(.WIDTH(W), .READ_LATENCY(0)) dut0 (
        .clock(clock), .reset(reset), .fifo_empty(fifo_empty0), .fifo_q(fifo_q0),
        .fifo_rdreq(fifo_rdreq0), .out_valid(out_valid0), .out_data(out_data0),
        .out_ready(out_ready0)
`ifdef HULL_FIFO_READER_STATS_EN
        , .beat_count(beat_count0)
`endif
    );

    hull_fifo_reader #(.WIDTH(W), .READ_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .fifo_empty(fifo_empty1), .fifo_q(fifo_q1),
        .fifo_rdreq(fifo_rdreq1), .out_valid(out_valid1), .out_data(out_data1),
        .out_ready(out_ready1)
`ifdef HULL_FIFO_READER_STATS_EN
        , .beat_count(beat_count1)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Upstream FIFO contents and the reference model of the adapter's buffering.
    logic [W-1:0] up_mem [2][UP_SZ];
    int           up_wr [2];
    int           up_rd [2];
    int           exp_acc [2];
    logic [W-1:0] mbuf [2][4];
    int           mcnt [2];
    bit           minfl;
    logic [W-1:0] q1_reg;
    int           ready_pct [2];
    int           gap_pct [2];
    int           cyc;
    int           first_rdreq_cyc [2], first_valid_cyc [2];
    int           first_acc_cyc [2], last_acc_cyc [2];
    int           acc_total [2], rdreq_pulses [2];

    task automatic clear_model();
        for (int l = 0; l < 2; l++) begin
            up_wr[l] = 0; up_rd[l] = 0; exp_acc[l] = 0; mcnt[l] = 0;
            first_rdreq_cyc[l] = -1; first_valid_cyc[l] = -1;
            first_acc_cyc[l] = -1; last_acc_cyc[l] = -1;
            acc_total[l] = 0; rdreq_pulses[l] = 0;
            ready_pct[l] = 100; gap_pct[l] = 0;
        end
        minfl = 1'b0; q1_reg = '0; cyc = 0;
    endtask

    task automatic load(input int l, input int n);
        for (int i = 0; i < n && up_wr[l] < UP_SZ; i++) begin
            up_mem[l][up_wr[l]] = $urandom;
            up_wr[l]++;
        end
    endtask

    // One clock cycle: drive, compare against the model, then advance the model past the edge.
    task automatic cycle();
        bit           emp [2], rdy [2], rq_exp [2], v_exp [2];
        logic         rq_act [2], v_act [2];
        logic [W-1:0] d_act [2];
        int           depth;
        @(negedge clock);
        for (int l = 0; l < 2; l++) begin
            emp[l] = (up_rd[l] == up_wr[l]) || ($urandom_range(99) < gap_pct[l]);
            rdy[l] = ($urandom_range(99) < ready_pct[l]);
        end
        fifo_empty0 = emp[0]; fifo_empty1 = emp[1];
        out_ready0  = rdy[0]; out_ready1  = rdy[1];
        fifo_q0     = up_mem[0][up_rd[0] % UP_SZ];
        fifo_q1     = q1_reg;
        #1;
        rq_act[0] = fifo_rdreq0; rq_act[1] = fifo_rdreq1;
        v_act[0]  = out_valid0;  v_act[1]  = out_valid1;
        d_act[0]  = out_data0;   d_act[1]  = out_data1;
        checks += 2;
        if (int'(dut0.u_buf.occ) + int'(dut0.inflight) > 2) begin
            errors++; $display("FAIL occupancy lane0 cyc%0d: occ+inflight=%0d limit=2", cyc, int'(dut0.u_buf.occ) + int'(dut0.inflight));
        end
        if (int'(dut1.u_buf.occ) + int'(dut1.inflight) > 3) begin
            errors++; $display("FAIL occupancy lane1 cyc%0d: occ+inflight=%0d limit=3", cyc, int'(dut1.u_buf.occ) + int'(dut1.inflight));
        end
        for (int l = 0; l < 2; l++) begin
            depth     = l + 2;
            rq_exp[l] = !emp[l] && (mcnt[l] + ((l == 1) ? int'(minfl) : 0) < depth);
            v_exp[l]  = (mcnt[l] != 0);
            checks++;
            if (rq_act[l] !== rq_exp[l]) begin
                errors++; $display("FAIL rdreq lane%0d cyc%0d: got=%b exp=%b", l, cyc, rq_act[l], rq_exp[l]);
            end
            checks++;
            if (v_act[l] !== v_exp[l]) begin
                errors++; $display("FAIL out_valid lane%0d cyc%0d: got=%b exp=%b", l, cyc, v_act[l], v_exp[l]);
            end
            if (v_exp[l]) begin
                checks++;
                if (d_act[l] !== mbuf[l][0]) begin
                    errors++; $display("FAIL out_data lane%0d cyc%0d: got=%h exp=%h", l, cyc, d_act[l], mbuf[l][0]);
                end
                if (first_valid_cyc[l] < 0) first_valid_cyc[l] = cyc;
            end
            if (v_exp[l] && rdy[l]) begin
                checks++;
                if (d_act[l] !== up_mem[l][exp_acc[l]]) begin
                    errors++; $display("FAIL scoreboard lane%0d beat%0d: got=%h exp=%h", l, exp_acc[l], d_act[l], up_mem[l][exp_acc[l]]);
                end
                exp_acc[l]++; acc_total[l]++;
                if (first_acc_cyc[l] < 0) first_acc_cyc[l] = cyc;
                last_acc_cyc[l] = cyc;
                for (int k = 0; k < 3; k++) mbuf[l][k] = mbuf[l][k+1];
                mcnt[l]--;
            end
            if (l == 0) begin
                if (rq_exp[0]) begin mbuf[0][mcnt[0]] = up_mem[0][up_rd[0]]; mcnt[0]++; end
            end else begin
                if (minfl) begin mbuf[1][mcnt[1]] = q1_reg; mcnt[1]++; end
                if (rq_exp[1]) q1_reg = up_mem[1][up_rd[1]];
                minfl = rq_exp[1];
            end
            if (rq_exp[l]) begin
                up_rd[l]++; rdreq_pulses[l]++;
                if (first_rdreq_cyc[l] < 0) first_rdreq_cyc[l] = cyc;
            end
        end
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        fifo_empty0 = 1'b1; fifo_empty1 = 1'b1; out_ready0 = 1'b0; out_ready1 = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        clear_model();
    endtask

    task automatic test_reset();
        fifo_empty0 = 1'b0; fifo_empty1 = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks += 6;
        if (fifo_rdreq0 !== 1'b0) begin errors++; $display("FAIL reset_rdreq0: got=%b exp=0", fifo_rdreq0); end
        if (fifo_rdreq1 !== 1'b0) begin errors++; $display("FAIL reset_rdreq1: got=%b exp=0", fifo_rdreq1); end
        if (out_valid0 !== 1'b0)  begin errors++; $display("FAIL reset_valid0: got=%b exp=0", out_valid0); end
        if (out_valid1 !== 1'b0)  begin errors++; $display("FAIL reset_valid1: got=%b exp=0", out_valid1); end
        if (out_data0 !== '0)     begin errors++; $display("FAIL reset_data0: got=%h exp=0", out_data0); end
        if (out_data1 !== '0)     begin errors++; $display("FAIL reset_data1: got=%h exp=0", out_data1); end
        @(posedge clock); #1;
        checks++;
        if (fifo_rdreq1 !== 1'b0) begin errors++; $display("FAIL reset_hold_rdreq: got=%b exp=0", fifo_rdreq1); end
        fifo_empty0 = 1'b1; fifo_empty1 = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        clear_model();
    endtask

    task automatic test_preload_lat0();
        apply_reset();
        up_mem[0][0] = 32'h11; up_mem[0][1] = 32'h22; up_mem[0][2] = 32'h33; up_wr[0] = 3;
        for (int i = 0; i < 5; i++) cycle();
        checks += 5;
        if (first_rdreq_cyc[0] != 0) begin errors++; $display("FAIL lat0_first_rdreq: got=%0d exp=0", first_rdreq_cyc[0]); end
        if (first_valid_cyc[0] != 1) begin errors++; $display("FAIL lat0_first_valid: got=%0d exp=1", first_valid_cyc[0]); end
        if (last_acc_cyc[0] != 3)    begin errors++; $display("FAIL lat0_last_beat: got=%0d exp=3", last_acc_cyc[0]); end
        if (acc_total[0] != 3)       begin errors++; $display("FAIL lat0_beats: got=%0d exp=3", acc_total[0]); end
        if (out_valid0 !== 1'b0)     begin errors++; $display("FAIL lat0_drained_valid: got=%b exp=0", out_valid0); end
    endtask

    task automatic test_stream_lat1();
        apply_reset();
        load(1, 100);
        for (int i = 0; i < 105; i++) cycle();
        checks += 4;
        if (first_valid_cyc[1] != first_rdreq_cyc[1] + 2) begin
            errors++; $display("FAIL lat1_fill: valid_cyc=%0d exp=%0d", first_valid_cyc[1], first_rdreq_cyc[1] + 2);
        end
        if (first_rdreq_cyc[1] != 0) begin errors++; $display("FAIL lat1_first_rdreq: got=%0d exp=0", first_rdreq_cyc[1]); end
        if (acc_total[1] != 100) begin errors++; $display("FAIL lat1_beats: got=%0d exp=100", acc_total[1]); end
        if (last_acc_cyc[1] - first_acc_cyc[1] != 99) begin
            errors++; $display("FAIL lat1_back_to_back: span=%0d exp=99", last_acc_cyc[1] - first_acc_cyc[1]);
        end
`ifdef HULL_FIFO_READER_STATS_EN
        checks++;
        if (beat_count1 !== 32'd100) begin errors++; $display("FAIL lat1_beat_count: got=%0d exp=100", beat_count1); end
`endif
    endtask

    task automatic test_backpressure();
        apply_reset();
        load(1, 10);
        ready_pct[1] = 0;
        for (int i = 0; i < 20; i++) cycle();
        checks += 3;
        if (rdreq_pulses[1] != 3) begin errors++; $display("FAIL bp_rdreq_pulses: got=%0d exp=3", rdreq_pulses[1]); end
        if (out_valid1 !== 1'b1)  begin errors++; $display("FAIL bp_valid: got=%b exp=1", out_valid1); end
        if (out_data1 !== up_mem[1][0]) begin errors++; $display("FAIL bp_hold_data: got=%h exp=%h", out_data1, up_mem[1][0]); end
        ready_pct[1] = 100;
        for (int i = 0; i < 40 && acc_total[1] < 10; i++) cycle();
        checks += 2;
        if (acc_total[1] != 10)  begin errors++; $display("FAIL bp_drain: got=%0d exp=10", acc_total[1]); end
        if (exp_acc[1] != up_wr[1]) begin errors++; $display("FAIL bp_loss: delivered=%0d loaded=%0d", exp_acc[1], up_wr[1]); end
    endtask

    task automatic test_random();
        apply_reset();
        load(0, 10000); load(1, 10000);
        for (int l = 0; l < 2; l++) begin ready_pct[l] = 50; gap_pct[l] = 30; end
        for (int i = 0; i < 60000 && (acc_total[0] < 10000 || acc_total[1] < 10000); i++) cycle();
        for (int l = 0; l < 2; l++) begin
            checks += 2;
            if (acc_total[l] != 10000) begin errors++; $display("FAIL rand_beats lane%0d: got=%0d exp=10000", l, acc_total[l]); end
            if (exp_acc[l] != up_wr[l]) begin errors++; $display("FAIL rand_loss lane%0d: delivered=%0d loaded=%0d", l, exp_acc[l], up_wr[l]); end
        end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        load(0, 50); load(1, 50);
        for (int i = 0; i < 6; i++) cycle();
        @(posedge clock); #2;
        checks++;
        if (dut1.inflight !== minfl) begin errors++; $display("FAIL mid_inflight_pre: got=%b exp=%b", dut1.inflight, minfl); end
        fifo_empty0 = 1'b0; fifo_empty1 = 1'b0;
        reset = 1'b1;
        #1;
        checks += 5;
        if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin errors++; $display("FAIL mid_valid: got=%b%b exp=00", out_valid0, out_valid1); end
        if (out_data0 !== '0 || out_data1 !== '0) begin errors++; $display("FAIL mid_data: got=%h/%h exp=0", out_data0, out_data1); end
        if (fifo_rdreq0 !== 1'b0) begin errors++; $display("FAIL mid_rdreq0: got=%b exp=0", fifo_rdreq0); end
        if (fifo_rdreq1 !== 1'b0) begin errors++; $display("FAIL mid_rdreq1: got=%b exp=0", fifo_rdreq1); end
        if (dut1.inflight !== 1'b0) begin errors++; $display("FAIL mid_inflight: got=%b exp=0", dut1.inflight); end
        @(posedge clock); #1;
        checks++;
        if (fifo_rdreq1 !== 1'b0) begin errors++; $display("FAIL mid_hold_rdreq: got=%b exp=0", fifo_rdreq1); end
        fifo_empty0 = 1'b1; fifo_empty1 = 1'b1; out_ready0 = 1'b0; out_ready1 = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        clear_model();
        load(0, 20); load(1, 20);
        for (int i = 0; i < 60 && (acc_total[0] < 20 || acc_total[1] < 20); i++) cycle();
        checks += 2;
        if (acc_total[0] != 20) begin errors++; $display("FAIL mid_resume lane0: got=%0d exp=20", acc_total[0]); end
        if (acc_total[1] != 20) begin errors++; $display("FAIL mid_resume lane1: got=%0d exp=20", acc_total[1]); end
    endtask

`ifdef HULL_FIFO_READER_STATS_EN
    task automatic test_stats_wrap();
        apply_reset();
        force dut0.beat_count = 32'hFFFF_FFFF;
        #1 release dut0.beat_count;
        load(0, 2);
        for (int i = 0; i < 5; i++) cycle();
        checks++;
        if (beat_count0 !== 32'd1) begin errors++; $display("FAIL stats_wrap: got=%h exp=00000001", beat_count0); end
    endtask
`endif

    initial begin
        clear_model();
        test_reset();
        test_preload_lat0();
        test_stream_lat1();
        test_backpressure();
        test_random();
        test_reset_midstream();
`ifdef HULL_FIFO_READER_STATS_EN
        test_stats_wrap();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
